// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator: drives f_pc, follows predictor hints, and checks every
// prediction against the EXEC resolution. Optional redirect counter: FETCH_MISPRED_CNT_EN.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] f_pc,
  output logic        f_valid,
  input  logic        f_ready,
  input  logic [31:0] f_predict_addr,
  input  logic        f_predict_valid,
  input  logic        x_valid,
  input  logic        x_is_branch,
  input  logic        x_taken,
  input  logic [31:0] x_target,
  output logic        x_flush,
  output logic [31:0] mispred_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_pred [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic          in_reset;
  logic [31:0]   pc;
  logic          flush_q;

  logic          accept;
  logic          pop;
  logic          mispredict;
  logic [31:0]   pred;
  logic [31:0]   actual;

  assign f_pc    = pc;
  assign x_flush = flush_q;
  assign f_valid = ~in_reset & (count != FULL);

  always_comb begin
    accept     = f_valid & f_ready;
    pred       = f_predict_valid ? f_predict_addr : pc + 32'd4;
    pop        = x_valid & (count != '0);
    actual     = (x_is_branch & x_taken) ? x_target : q_pc[head] + 32'd4;
    mispredict = pop & (actual != q_pred[head]);
  end

  // Storage carries no reset; entries are only read while count says they are live.
  always_ff @(posedge clk) begin
    if (accept & ~mispredict) begin
      q_pc[tail]   <= pc;
      q_pred[tail] <= pred;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      in_reset <= 1'b1;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      flush_q  <= 1'b0;
    end else begin
      in_reset <= 1'b0;
      flush_q  <= mispredict;
      if (mispredict) begin
        // Redirect wins over any same-cycle push: the whole queue is squashed.
        pc    <= actual;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (accept) begin
          pc   <= pred;
          tail <= tail + 1'b1;
        end
        if (pop) begin
          head <= head + 1'b1;
        end
        case ({accept, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef FETCH_MISPRED_CNT_EN
  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (mispredict && (cnt != '1)) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign mispred_count = cnt;
`else
  assign mispred_count = '0;
`endif

endmodule
